// File: rtl/sap_control_sequencer_if.sv
// Bus/control bundle between the SAP-U control sequencer and the datapath top level.
// Ports: bus and ram_prog_mode flow into the sequencer; PC/IR bus offers, step, halted
//        and all datapath control lines flow out of it.
interface sap_control_sequencer_if;
  logic [7:0] bus;
  logic       ram_prog_mode;
  logic       pc_enable;
  logic [3:0] pc_value;
  logic       ir_enable;
  logic [3:0] ir_operand;
  logic [3:0] ir_opcode;
  logic [2:0] step;
  logic       ram_load_mar_reg;
  logic       ram_output_enable;
  logic       ram_write_enable;
  logic       reg_a_load;
  logic       reg_a_enable;
  logic       reg_b_load;
  logic       alu_enable;
  logic       alu_subtract;
  logic       out_load;
  logic       halted;

  // Sequencer side
  modport master (
    input  bus, ram_prog_mode,
    output pc_enable, pc_value, ir_enable, ir_operand, ir_opcode, step,
           ram_load_mar_reg, ram_output_enable, ram_write_enable,
           reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract,
           out_load, halted
  );

  // Datapath / top-level side
  modport slave (
    output bus, ram_prog_mode,
    input  pc_enable, pc_value, ir_enable, ir_operand, ir_opcode, step,
           ram_load_mar_reg, ram_output_enable, ram_write_enable,
           reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract,
           out_load, halted
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-U control sequencer: PC, IR and a 5-step microstep counter decoded into datapath controls.
// Ports: clk, reset (async active-high) and the sequencer bundle (master modport).
// Controls are combinational from state; every instruction takes exactly STEPS clocks.
module sap_control_sequencer #(
  parameter int STEPS = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  sap_control_sequencer_if.master      sif
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  step_t      step_q, step_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       halted_q, halted_d;

  logic pc_en, ir_en, mar_ld, ram_oe, ram_we, a_ld, a_en, b_ld, alu_en, alu_sub, out_ld;
  logic run;

  wire [3:0] opcode = ir_q[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      pc_q     <= 4'd0;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Program mode outranks halt; both freeze every piece of state.
  assign run = !sif.ram_prog_mode && !halted_q;

  always_comb begin
    step_d   = step_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    if (run) begin
      if (int'(step_q) == STEPS - 1) step_d = T0;
      else                           step_d = step_t'(step_q + 3'd1);
      if (step_q == T1) begin
        ir_d = sif.bus;
        pc_d = pc_q + 4'd1;
      end else if (step_q == T2 && opcode == OP_JMP) begin
        pc_d = sif.bus[3:0];
      end else if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end
    end
  end

  // Reset is included directly so controls drop the instant reset rises,
  // not only once the async clear has propagated through the state.
  always_comb begin
    pc_en   = 1'b0;
    ir_en   = 1'b0;
    mar_ld  = 1'b0;
    ram_oe  = 1'b0;
    ram_we  = 1'b0;
    a_ld    = 1'b0;
    a_en    = 1'b0;
    b_ld    = 1'b0;
    alu_en  = 1'b0;
    alu_sub = 1'b0;
    out_ld  = 1'b0;
    if (!reset && run) begin
      unique case (step_q)
        T0: begin pc_en = 1'b1; mar_ld = 1'b1; end
        T1: ram_oe = 1'b1;
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_en = 1'b1; mar_ld = 1'b1; end
            OP_LDI:                         begin ir_en = 1'b1; a_ld = 1'b1; end
            OP_JMP:                         ir_en = 1'b1;
            OP_OUT:                         begin a_en = 1'b1; out_ld = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA:         begin ram_oe = 1'b1; a_ld = 1'b1; end
            OP_ADD, OP_SUB: begin ram_oe = 1'b1; b_ld = 1'b1; end
            OP_STA:         begin a_en = 1'b1; ram_we = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_en  = 1'b1;
            a_ld    = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign sif.pc_enable         = pc_en;
  assign sif.ir_enable         = ir_en;
  assign sif.ram_load_mar_reg  = mar_ld;
  assign sif.ram_output_enable = ram_oe;
  assign sif.ram_write_enable  = ram_we;
  assign sif.reg_a_load        = a_ld;
  assign sif.reg_a_enable      = a_en;
  assign sif.reg_b_load        = b_ld;
  assign sif.alu_enable        = alu_en;
  assign sif.alu_subtract      = alu_sub;
  assign sif.out_load          = out_ld;
  assign sif.pc_value          = pc_q;
  assign sif.ir_operand        = ir_q[3:0];
  assign sif.ir_opcode         = ir_q[7:4];
  assign sif.step              = step_q;
  assign sif.halted            = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
module tb_sap_control_sequencer;

  logic clk = 1'b0;
  logic reset;
  sap_control_sequencer_if sif ();

  sap_control_sequencer #(.STEPS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Control vector bit positions
  localparam logic [10:0] PCE = 11'h400, IRE = 11'h200, MAR = 11'h100, ROE = 11'h080,
                          RWE = 11'h040, AL  = 11'h020, AE  = 11'h010, BL  = 11'h008,
                          ALU = 11'h004, SUB = 11'h002, OUT = 11'h001;

  logic [10:0] ucode [0:15][0:4];

  // Reference model state
  int         m_pc, m_step;
  logic [7:0] m_ir;
  bit         m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] dut_ctrl();
    return {sif.pc_enable, sif.ir_enable, sif.ram_load_mar_reg, sif.ram_output_enable,
            sif.ram_write_enable, sif.reg_a_load, sif.reg_a_enable, sif.reg_b_load,
            sif.alu_enable, sif.alu_subtract, sif.out_load};
  endfunction

  task automatic model_clear();
    m_pc = 0; m_step = 0; m_ir = 8'h00; m_halt = 0;
  endtask

  task automatic check_all();
    logic [10:0] ec;
    ec = (reset || m_halt || sif.ram_prog_mode) ? 11'h0 : ucode[m_ir[7:4]][m_step];
    chk("ctrl",   32'(dut_ctrl()),       32'(ec));
    chk("step",   32'(sif.step),         32'(m_step));
    chk("pc",     32'(sif.pc_value),     32'(m_pc));
    chk("ir_op",  32'(sif.ir_opcode),    32'(m_ir[7:4]));
    chk("ir_opd", 32'(sif.ir_operand),   32'(m_ir[3:0]));
    chk("halted", 32'(sif.halted),       32'(m_halt));
  endtask

  // Apply inputs at the falling edge and check the combinational result.
  task automatic drive(input logic [7:0] b, input logic p, input logic r);
    @(negedge clk);
    sif.bus = b; sif.ram_prog_mode = p; reset = r;
    if (r) model_clear();
    #1 check_all();
  endtask

  // Advance model across the rising edge using the inputs held there.
  task automatic tick();
    int op;
    @(posedge clk);
    op = m_ir[7:4];
    if (reset) model_clear();
    else if (!sif.ram_prog_mode && !m_halt) begin
      if (m_step == 1) begin
        m_ir = sif.bus;
        m_pc = (m_pc + 1) % 16;
      end else if (m_step == 2 && op == 6) m_pc = sif.bus % 16;
      else if (m_step == 2 && op == 15) m_halt = 1;
      m_step = (m_step + 1) % 5;
    end
  endtask

  task automatic cyc(input logic [7:0] b, input logic p, input logic r);
    drive(b, p, r);
    tick();
  endtask

  // One full instruction: instr fetched in T1, t2bus presented in T2.
  task automatic run_instr(input logic [7:0] instr, input logic [7:0] t2bus);
    cyc(8'($urandom), 0, 0);
    cyc(instr, 0, 0);
    cyc(t2bus, 0, 0);
    cyc(8'($urandom), 0, 0);
    cyc(8'($urandom), 0, 0);
  endtask

  task automatic do_reset();
    cyc(8'h00, 0, 1);
    cyc(8'h00, 0, 1);
  endtask

  initial begin
    for (int op = 0; op < 16; op++)
      for (int st = 0; st < 5; st++) ucode[op][st] = 11'h0;
    for (int op = 0; op < 16; op++) begin
      ucode[op][0] = PCE | MAR;
      ucode[op][1] = ROE;
    end
    ucode[1][2] = IRE | MAR; ucode[1][3] = ROE | AL;
    ucode[2][2] = IRE | MAR; ucode[2][3] = ROE | BL; ucode[2][4] = ALU | AL;
    ucode[3][2] = IRE | MAR; ucode[3][3] = ROE | BL; ucode[3][4] = ALU | AL | SUB;
    ucode[4][2] = IRE | MAR; ucode[4][3] = AE | RWE;
    ucode[5][2] = IRE | AL;
    ucode[6][2] = IRE;
    ucode[14][2] = AE | OUT;

    sif.bus = 8'h00; sif.ram_prog_mode = 1'b0; reset = 1'b0;
    model_clear();
    #1 reset = 1'b1;
    #1;
    chk("rst_step", 32'(sif.step), 0);
    chk("rst_pc",   32'(sif.pc_value), 0);
    chk("rst_ctrl", 32'(dut_ctrl()), 0);
    chk("rst_halt", 32'(sif.halted), 0);
    do_reset();

    // Reset then fetch of 0x1E
    drive(8'h00, 0, 0);
    chk("t0_fetch", 32'({sif.pc_enable, sif.ram_load_mar_reg}), 32'h3);
    tick();
    cyc(8'h1E, 0, 0);
    #2;
    chk("fetch_ir", 32'(sif.ir_opcode), 32'h1);
    chk("fetch_operand", 32'(sif.ir_operand), 32'hE);
    chk("fetch_pc", 32'(sif.pc_value), 32'h1);
    cyc(8'h00, 0, 0); cyc(8'h00, 0, 0); cyc(8'h00, 0, 0);

    // ADD and SUB
    run_instr(8'h27, 8'h55);
    run_instr(8'h37, 8'hAA);

    // Walk PC to 15, then wrap
    for (int i = 0; i < 20 && m_pc != 15; i++) run_instr(8'h00, 8'h00);
    chk("pc_at_15", 32'(sif.pc_value), 32'd15);
    run_instr(8'h50, 8'h00);
    chk("pc_wrap", 32'(sif.pc_value), 32'd0);

    // JMP with upper nibble ignored
    run_instr(8'h60, 8'hA3);
    #2;
    chk("jmp_pc", 32'(sif.pc_value), 32'd3);
    chk("jmp_t0", 32'(sif.step), 32'd0);
    run_instr(8'hE0, 8'h00);

    // HLT freezes everything
    run_instr(8'hF0, 8'h00);
    chk("hlt_flag", 32'(sif.halted), 1);
    for (int i = 0; i < 20; i++) cyc(8'($urandom), 0, 0);
    chk("hlt_step", 32'(sif.step), 32'd3);
    do_reset();
    chk("hlt_clear", 32'(sif.halted), 0);

    // Program mode during LDA T3
    cyc(8'h00, 0, 0); cyc(8'h1A, 0, 0); cyc(8'h00, 0, 0);
    for (int i = 0; i < 10; i++) cyc(8'($urandom), 1, 0);
    drive(8'h00, 0, 0);
    chk("prog_resume_step", 32'(sif.step), 32'd3);
    chk("prog_resume_ctrl", 32'(dut_ctrl()), 32'(ROE | AL));
    tick();
    cyc(8'h00, 0, 0);

    // Async reset mid STA T3
    cyc(8'h00, 0, 0); cyc(8'h49, 0, 0); cyc(8'h00, 0, 0);
    drive(8'h00, 0, 0);
    chk("sta_rwe", 32'(sif.ram_write_enable), 1);
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("midrst_rwe",  32'(sif.ram_write_enable), 0);
    chk("midrst_pc",   32'(sif.pc_value), 0);
    chk("midrst_ir",   32'({sif.ir_opcode, sif.ir_operand}), 0);
    chk("midrst_step", 32'(sif.step), 0);
    tick();

    // Randomized run
    for (int i = 0; i < 1500; i++) begin
      logic r, p;
      r = ($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 99) < 6);
      cyc(8'($urandom), p, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
